crc_check: RTL and testbench
============================

CRC_CHECK -- requirements
Module: crc_check

Interface
REQ-001 SHALL have parameter SEED, default 16'h0000, giving the LFSR preset value at reset and at every frame start.
REQ-002 SHALL have port CLK  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port RST  input  1  reset; synchronous and active-high.
REQ-004 SHALL have port DATA  input  1  serial bit: a payload bit when DATA_EN=1, a received CRC bit when CRC_EN=1.
REQ-005 SHALL have port DATA_EN  input  1  qualifies DATA as a payload bit.
REQ-006 SHALL have port CRC_EN  input  1  qualifies DATA as a received CRC bit, MSB-first.
REQ-007 SHALL have port Valid  output  1  one-cycle pulse marking a completed or aborted frame verdict.
REQ-008 SHALL have port crc_ok  output  1  received CRC matched the computed CRC; held until the next frame start.
REQ-009 SHALL have port crc_err  output  1  received CRC mismatched, or the frame was aborted; held until the next frame start.
REQ-010 SHALL have port busy  output  1  high in states PAYLOAD and CHECK.
REQ-011 SHALL have port calc_crc  output  16  LFSR snapshot taken when CHECK is entered.
REQ-012 SHALL have port rx_crc  output  16  received CRC bits assembled MSB-first.

Function
REQ-013 SHALL implement FSM states IDLE, PAYLOAD and CHECK.
REQ-014 SHALL, on each accepted payload bit, compute fb = DATA ^ lfsr[0] and update lfsr[0]=fb, lfsr[i]=lfsr[i-1] for i = 1..15, except lfsr[5]=lfsr[4]^fb and lfsr[12]=lfsr[11]^fb.
REQ-015 SHALL treat the CRC bit stream as lfsr[15] first down to lfsr[0] last, so a good frame gives rx_crc == calc_crc.
REQ-016 SHALL, in IDLE with DATA_EN=1, load lfsr as SEED advanced by DATA, clear crc_ok, crc_err and rx_crc, and move to PAYLOAD.
REQ-017 SHALL, in IDLE with only CRC_EN=1 (empty payload), snapshot calc_crc=SEED, take the first CRC bit, set count=1 and move to CHECK.
REQ-018 SHALL, in PAYLOAD, advance lfsr on each DATA_EN and hold lfsr when neither enable is high (gaps allowed).
REQ-019 SHALL, in PAYLOAD with CRC_EN=1, snapshot calc_crc=lfsr, set rx_crc={rx_crc[14:0],DATA}, set count=1 and move to CHECK.
REQ-020 SHALL, in CHECK, shift each CRC_EN bit into rx_crc LSB and increment a 5-bit count; cycles with no enable hold state.
REQ-021 SHALL, on the 16th CRC bit, register crc_ok=(rx_crc_next==calc_crc) and crc_err as its complement, pulse Valid for one cycle, reseed lfsr=SEED and go to IDLE; the verdict is visible the cycle after that edge.
REQ-022 SHALL give DATA_EN priority when DATA_EN and CRC_EN are both high, ignoring CRC_EN.
REQ-023 SHALL, on DATA_EN in CHECK (abort), pulse Valid with crc_err=1 and crc_ok=0, then restart in PAYLOAD with lfsr = SEED advanced by DATA.
REQ-024 SHALL accept DATA_EN in the cycle in which Valid is high, starting the next frame back-to-back.
REQ-025 SHALL keep count within 0..16 and never wrap it.

Reset
REQ-026 SHALL, while RST=1 at a clock edge, set state=IDLE, lfsr=SEED, count=0, Valid=0, crc_ok=0, crc_err=0, busy=0, calc_crc=0 and rx_crc=0.
REQ-027 SHALL, on reset mid-frame, discard the frame silently with no Valid pulse.

Structure
REQ-028 SHALL place the FSM state encoding, the CRC width (16) and the tap positions (5, 12) in a shared CRC package that the generator also uses.
REQ-029 SHALL contain one sub-module, crc16_lfsr_step: a combinational next-state function with inputs lfsr and DATA and output lfsr_next.

Verification
REQ-030 SHALL test SEED=0 with 8 payload bits of 0 followed by 16 CRC bits of 0 -> calc_crc=16'h0000, rx_crc=16'h0000, crc_ok=1, one Valid pulse.
REQ-031 SHALL test SEED=0 with 1 payload bit of 1 followed by CRC bits 0001_0000_0010_0001 -> calc_crc=16'h1021, rx_crc=16'h1021, crc_ok=1.
REQ-032 SHALL test the REQ-031 frame with the last CRC bit flipped -> rx_crc=16'h1020, crc_err=1, crc_ok=0.
REQ-033 SHALL test DATA_EN after 7 CRC bits -> Valid pulse with crc_err=1 in the next cycle, then busy=1 and the new frame proceeds correctly.
REQ-034 SHALL test RST asserted after 5 CRC bits -> no Valid pulse, all outputs 0; a following good frame gives crc_ok=1.
REQ-035 SHALL test the REQ-031 frame run back-to-back with DATA_EN in the Valid cycle and idle gaps inserted -> two Valid pulses, both crc_ok=1.

Source files
------------

// File: rtl/crc_check_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// crc_check_pkg : shared CRC-16 width, tap positions and checker FSM states
// Revision 1.0
// ----------------------------------------------------------------------------
package crc_check_pkg;

  localparam int         c_CRC_WIDTH = 16;
  localparam int         c_TAP_LO    = 5;
  localparam int         c_TAP_HI    = 12;
  localparam logic [4:0] c_CRC_BITS  = 5'd16;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PAYLOAD = 2'd1,
    CHECK   = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/crc16_lfsr_step.sv
`default_nettype none
// ----------------------------------------------------------------------------
// crc16_lfsr_step : one-bit combinational advance of the CRC-16 LFSR
// Revision 1.0
// ----------------------------------------------------------------------------
module crc16_lfsr_step
  import crc_check_pkg::*;
(
  input  logic [c_CRC_WIDTH-1:0] lfsr,
  input  logic                   DATA,
  output logic [c_CRC_WIDTH-1:0] lfsr_next
);

  logic w_fb;

  assign w_fb = DATA ^ lfsr[0];

  always_comb begin
    lfsr_next           = {lfsr[c_CRC_WIDTH-2:0], w_fb};
    lfsr_next[c_TAP_LO] = lfsr[c_TAP_LO-1] ^ w_fb;
    lfsr_next[c_TAP_HI] = lfsr[c_TAP_HI-1] ^ w_fb;
  end

endmodule
`default_nettype wire

// File: rtl/crc_check.sv
`default_nettype none
// ----------------------------------------------------------------------------
// crc_check : serial CRC-16 frame checker (payload bits, then received CRC)
// Revision 1.0
// ----------------------------------------------------------------------------
module crc_check
  import crc_check_pkg::*;
#(
  parameter logic [c_CRC_WIDTH-1:0] SEED = 16'h0000
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   DATA,
  input  logic                   DATA_EN,
  input  logic                   CRC_EN,
  output logic                   Valid,
  output logic                   crc_ok,
  output logic                   crc_err,
  output logic                   busy,
  output logic [c_CRC_WIDTH-1:0] calc_crc,
  output logic [c_CRC_WIDTH-1:0] rx_crc
);

  state_t                 r_state, w_state_next;
  logic [c_CRC_WIDTH-1:0] r_lfsr, w_lfsr_next;
  logic [4:0]             r_count, w_count_next;
  logic                   r_valid, w_valid_next;
  logic                   r_ok, w_ok_next;
  logic                   r_err, w_err_next;
  logic [c_CRC_WIDTH-1:0] r_calc, w_calc_next;
  logic [c_CRC_WIDTH-1:0] r_rx, w_rx_next;

  logic [c_CRC_WIDTH-1:0] w_step_in, w_step_out, w_rx_shift;

  // Outside PAYLOAD a payload bit always starts a fresh frame from SEED.
  assign w_step_in  = (r_state == PAYLOAD) ? r_lfsr : SEED;
  assign w_rx_shift = {r_rx[c_CRC_WIDTH-2:0], DATA};

  crc16_lfsr_step u_step (
    .lfsr      (w_step_in),
    .DATA      (DATA),
    .lfsr_next (w_step_out)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= IDLE;
      r_lfsr  <= SEED;
      r_count <= 5'd0;
      r_valid <= 1'b0;
      r_ok    <= 1'b0;
      r_err   <= 1'b0;
      r_calc  <= '0;
      r_rx    <= '0;
    end else begin
      r_state <= w_state_next;
      r_lfsr  <= w_lfsr_next;
      r_count <= w_count_next;
      r_valid <= w_valid_next;
      r_ok    <= w_ok_next;
      r_err   <= w_err_next;
      r_calc  <= w_calc_next;
      r_rx    <= w_rx_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_lfsr_next  = r_lfsr;
    w_count_next = r_count;
    w_valid_next = 1'b0;
    w_ok_next    = r_ok;
    w_err_next   = r_err;
    w_calc_next  = r_calc;
    w_rx_next    = r_rx;

    case (r_state)
      IDLE: begin
        if (DATA_EN) begin
          w_lfsr_next  = w_step_out;
          w_ok_next    = 1'b0;
          w_err_next   = 1'b0;
          w_rx_next    = '0;
          w_count_next = 5'd0;
          w_state_next = PAYLOAD;
        end else if (CRC_EN) begin
          w_ok_next    = 1'b0;
          w_err_next   = 1'b0;
          w_calc_next  = SEED;
          w_rx_next    = {{(c_CRC_WIDTH-1){1'b0}}, DATA};
          w_count_next = 5'd1;
          w_state_next = CHECK;
        end
      end

      PAYLOAD: begin
        if (DATA_EN) begin
          w_lfsr_next = w_step_out;
        end else if (CRC_EN) begin
          w_calc_next  = r_lfsr;
          w_rx_next    = w_rx_shift;
          w_count_next = 5'd1;
          w_state_next = CHECK;
        end
      end

      CHECK: begin
        if (DATA_EN) begin
          // Abort: report the broken frame and treat this bit as the new frame's first.
          w_valid_next = 1'b1;
          w_ok_next    = 1'b0;
          w_err_next   = 1'b1;
          w_lfsr_next  = w_step_out;
          w_count_next = 5'd0;
          w_state_next = PAYLOAD;
        end else if (CRC_EN) begin
          w_rx_next    = w_rx_shift;
          w_count_next = r_count + 5'd1;
          if (r_count == c_CRC_BITS - 5'd1) begin
            w_valid_next = 1'b1;
            w_ok_next    = (w_rx_shift == r_calc);
            w_err_next   = (w_rx_shift != r_calc);
            w_lfsr_next  = SEED;
            w_state_next = IDLE;
          end
        end
      end

      default: begin
        w_state_next = IDLE;
        w_lfsr_next  = SEED;
        w_count_next = 5'd0;
      end
    endcase
  end

  assign Valid    = r_valid;
  assign crc_ok   = r_ok;
  assign crc_err  = r_err;
  assign busy     = (r_state == PAYLOAD) || (r_state == CHECK);
  assign calc_crc = r_calc;
  assign rx_crc   = r_rx;

endmodule
`default_nettype wire

// File: tb/tb_crc_check.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_crc_check : directed self-checking bench for crc_check (SEED = 0)
// Revision 1.0
// ----------------------------------------------------------------------------
module tb_crc_check;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        DATA = 1'b0;
  logic        DATA_EN = 1'b0;
  logic        CRC_EN = 1'b0;
  logic        Valid, crc_ok, crc_err, busy;
  logic [15:0] calc_crc, rx_crc;

  int n_vec = 0;
  int n_err = 0;
  int vcount = 0;

  crc_check #(.SEED(16'h0000)) dut (
    .CLK      (CLK),
    .RST      (RST),
    .DATA     (DATA),
    .DATA_EN  (DATA_EN),
    .CRC_EN   (CRC_EN),
    .Valid    (Valid),
    .crc_ok   (crc_ok),
    .crc_err  (crc_err),
    .busy     (busy),
    .calc_crc (calc_crc),
    .rx_crc   (rx_crc)
  );

  always #5 CLK = ~CLK;

  always @(negedge CLK) if (Valid === 1'b1) vcount++;

  task automatic drv(input logic de, input logic ce, input logic d);
    DATA_EN = de;
    CRC_EN  = ce;
    DATA    = d;
    @(posedge CLK);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drv(1'b0, 1'b0, 1'b0);
  endtask

  // Sends the top n bits of c, MSB first.
  task automatic send_crc(input logic [15:0] c, input int n);
    for (int i = 0; i < n; i++) drv(1'b0, 1'b1, c[15-i]);
  endtask

  task automatic test_reset();
    RST = 1'b1;
    idle(2);
    n_vec++; if ({Valid, crc_ok, crc_err, busy} !== 4'b0000) begin n_err++; $display("FAIL reset_flags: got %b exp 0000", {Valid, crc_ok, crc_err, busy}); end
    n_vec++; if (calc_crc !== 16'h0000) begin n_err++; $display("FAIL reset_calc: got %h exp 0000", calc_crc); end
    n_vec++; if (rx_crc !== 16'h0000) begin n_err++; $display("FAIL reset_rx: got %h exp 0000", rx_crc); end
    RST = 1'b0;
    idle(1);
  endtask

  task automatic test_zero_frame();
    int v0;
    v0 = vcount;
    for (int i = 0; i < 8; i++) drv(1'b1, 1'b0, 1'b0);
    n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL zero_busy: got %b exp 1", busy); end
    send_crc(16'h0000, 16);
    n_vec++; if ({Valid, crc_ok, crc_err} !== 3'b110) begin n_err++; $display("FAIL zero_verdict: got %b exp 110", {Valid, crc_ok, crc_err}); end
    n_vec++; if (calc_crc !== 16'h0000 || rx_crc !== 16'h0000) begin n_err++; $display("FAIL zero_crc: got calc %h rx %h exp 0000 0000", calc_crc, rx_crc); end
    idle(1);
    n_vec++; if ({Valid, crc_ok, busy} !== 3'b010) begin n_err++; $display("FAIL zero_hold: got %b exp 010", {Valid, crc_ok, busy}); end
    n_vec++; if (vcount !== v0 + 1) begin n_err++; $display("FAIL zero_pulses: got %0d exp %0d", vcount - v0, 1); end
  endtask

  task automatic test_single_one();
    drv(1'b1, 1'b0, 1'b1);
    send_crc(16'h1021, 16);
    n_vec++; if ({Valid, crc_ok, crc_err} !== 3'b110) begin n_err++; $display("FAIL one_verdict: got %b exp 110", {Valid, crc_ok, crc_err}); end
    n_vec++; if (calc_crc !== 16'h1021 || rx_crc !== 16'h1021) begin n_err++; $display("FAIL one_crc: got calc %h rx %h exp 1021 1021", calc_crc, rx_crc); end
    idle(1);
  endtask

  task automatic test_bad_crc();
    drv(1'b1, 1'b0, 1'b1);
    send_crc(16'h1020, 16);
    n_vec++; if ({Valid, crc_ok, crc_err} !== 3'b101) begin n_err++; $display("FAIL bad_verdict: got %b exp 101", {Valid, crc_ok, crc_err}); end
    n_vec++; if (rx_crc !== 16'h1020 || calc_crc !== 16'h1021) begin n_err++; $display("FAIL bad_crc: got rx %h calc %h exp 1020 1021", rx_crc, calc_crc); end
    idle(1);
    n_vec++; if ({Valid, crc_err} !== 2'b01) begin n_err++; $display("FAIL bad_hold: got %b exp 01", {Valid, crc_err}); end
  endtask

  task automatic test_empty_payload();
    send_crc(16'h0000, 16);
    n_vec++; if ({Valid, crc_ok, crc_err} !== 3'b110) begin n_err++; $display("FAIL empty_verdict: got %b exp 110", {Valid, crc_ok, crc_err}); end
    n_vec++; if (calc_crc !== 16'h0000) begin n_err++; $display("FAIL empty_calc: got %h exp 0000", calc_crc); end
    idle(1);
  endtask

  task automatic test_priority();
    drv(1'b1, 1'b0, 1'b1);
    drv(1'b1, 1'b1, 1'b0);
    send_crc(16'h3063, 16);
    n_vec++; if ({Valid, crc_ok} !== 2'b11) begin n_err++; $display("FAIL prio_verdict: got %b exp 11", {Valid, crc_ok}); end
    n_vec++; if (calc_crc !== 16'h3063) begin n_err++; $display("FAIL prio_calc: got %h exp 3063", calc_crc); end
    idle(1);
  endtask

  task automatic test_abort();
    drv(1'b1, 1'b0, 1'b1);
    send_crc(16'h1021, 7);
    drv(1'b1, 1'b0, 1'b1);
    n_vec++; if ({Valid, crc_ok, crc_err, busy} !== 4'b1011) begin n_err++; $display("FAIL abort_verdict: got %b exp 1011", {Valid, crc_ok, crc_err, busy}); end
    idle(1);
    n_vec++; if ({Valid, busy} !== 2'b01) begin n_err++; $display("FAIL abort_after: got %b exp 01", {Valid, busy}); end
    send_crc(16'h1021, 16);
    n_vec++; if ({Valid, crc_ok, crc_err} !== 3'b110 || calc_crc !== 16'h1021) begin n_err++; $display("FAIL abort_next: got %b calc %h exp 110 1021", {Valid, crc_ok, crc_err}, calc_crc); end
    idle(1);
  endtask

  task automatic test_reset_mid();
    int v0;
    drv(1'b1, 1'b0, 1'b1);
    send_crc(16'h1021, 5);
    v0 = vcount;
    RST = 1'b1;
    drv(1'b0, 1'b0, 1'b0);
    RST = 1'b0;
    n_vec++; if ({Valid, crc_ok, crc_err, busy} !== 4'b0000 || calc_crc !== 16'h0000 || rx_crc !== 16'h0000) begin n_err++; $display("FAIL midrst_outs: got %b calc %h rx %h exp 0000 0000 0000", {Valid, crc_ok, crc_err, busy}, calc_crc, rx_crc); end
    idle(3);
    n_vec++; if (vcount !== v0) begin n_err++; $display("FAIL midrst_pulse: got %0d exp 0", vcount - v0); end
    drv(1'b1, 1'b0, 1'b1);
    send_crc(16'h1021, 16);
    n_vec++; if ({Valid, crc_ok, crc_err} !== 3'b110) begin n_err++; $display("FAIL midrst_next: got %b exp 110", {Valid, crc_ok, crc_err}); end
    idle(1);
  endtask

  task automatic test_back_to_back();
    int v0;
    v0 = vcount;
    drv(1'b1, 1'b0, 1'b1);
    idle(2);
    send_crc(16'h1021, 8);
    idle(1);
    send_crc(16'h2100, 8);
    n_vec++; if ({Valid, crc_ok} !== 2'b11) begin n_err++; $display("FAIL b2b_first: got %b exp 11", {Valid, crc_ok}); end
    drv(1'b1, 1'b0, 1'b1);
    n_vec++; if ({Valid, busy} !== 2'b01) begin n_err++; $display("FAIL b2b_start: got %b exp 01", {Valid, busy}); end
    idle(3);
    send_crc(16'h1021, 4);
    idle(2);
    send_crc(16'h0210, 12);
    n_vec++; if ({Valid, crc_ok, crc_err} !== 3'b110 || rx_crc !== 16'h1021) begin n_err++; $display("FAIL b2b_second: got %b rx %h exp 110 1021", {Valid, crc_ok, crc_err}, rx_crc); end
    idle(1);
    n_vec++; if (vcount !== v0 + 2) begin n_err++; $display("FAIL b2b_pulses: got %0d exp 2", vcount - v0); end
  endtask

  initial begin
    test_reset();
    test_zero_frame();
    test_single_one();
    test_bad_crc();
    test_empty_payload();
    test_priority();
    test_abort();
    test_reset_mid();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
